// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state codes and parity-type constants,
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the word, inverted for odd parity.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: one-word holding buffer feeding a tick-paced
// start/data/parity/stop serializer with a registered TX line.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int BCNT_W     = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baud_tick,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_ready,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_uart_tx,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    uart_state_e           state;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  buf_full;
    logic [BCNT_W-1:0]     bit_cnt;
    logic                  stop_cnt;
    logic                  par_bit;
    logic                  par_bit_next;
    logic                  par_en_q;
    logic                  tx_q;
    logic                  done_q;

    logic accept;
    logic bit_last;
    logic stop_last;
    logic load_frame;

    assign accept     = i_data_valid && !buf_full;
    assign bit_last   = (bit_cnt == BCNT_W'(DATA_WIDTH - 1));
    assign stop_last  = (stop_cnt == 1'(STOP_BITS - 1));
    assign load_frame = i_baud_tick && buf_full &&
                        ((state == IDLE) || ((state == STOP) && stop_last));

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (buf_data),
        .par_typ (i_par_typ),
        .par_bit (par_bit_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            buf_full <= 1'b0;
            done_q   <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                buf_full <= 1'b1;
            end
            if (i_baud_tick) begin
                case (state)
                    IDLE: ;
                    START: begin
                        state   <= DATA;
                        tx_q    <= shreg[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_last) begin
                            stop_cnt <= 1'b0;
                            if (par_en_q) begin
                                state <= PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shreg[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_last) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                            tx_q   <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
            // Frame start overrides the IDLE/STOP outcome above, giving back-to-back frames.
            if (load_frame) begin
                state    <= START;
                tx_q     <= 1'b0;
                buf_full <= 1'b0;
                par_bit  <= par_bit_next;
                par_en_q <= i_par_en;
            end
        end
    end

    // Word storage and shifting need no reset; validity lives in buf_full and state.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_data <= i_data;
        end
        if (load_frame) begin
            shreg <= buf_data;
        end else if (i_baud_tick && (state == DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    assign o_ready      = !buf_full;
    assign o_busy       = (state != IDLE) || buf_full;
    assign o_uart_tx    = tx_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: directed frames with hand-computed bit patterns,
// checked by a per-instance line monitor against a queue of expected frames.
module tb_uart_tx_frame_gen;

    typedef struct packed {
        logic [15:0] bits;   // bit i is the i-th bit on the line, start bit first
        logic [4:0]  len;
        logic        b2b;    // frame must start on the edge that ends the previous one
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] data;
    logic       valid0, valid1;
    logic       par_en, par_typ;
    logic       tx0, ready0, busy0, done0;
    logic       tx1, ready1, busy1, done1;

    int   checks = 0;
    int   errors = 0;
    int   tick_div = 1;
    int   tcnt = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    bit   in_fr[2];
    int   idx[2];
    exp_t cur[2];
    logic prev_tx[2];
    logic mon_t;

    always #5 clk = ~clk;

    uart_tx_frame_gen #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data),
        .i_data_valid(valid0), .o_ready(ready0), .i_par_en(par_en),
        .i_par_typ(par_typ), .o_uart_tx(tx0), .o_busy(busy0), .o_frame_done(done0)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data),
        .i_data_valid(valid1), .o_ready(ready1), .i_par_en(par_en),
        .i_par_typ(par_typ), .o_uart_tx(tx1), .o_busy(busy1), .o_frame_done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] bits, input logic [4:0] len, input logic b2b);
        exp_t e;
        e.bits = bits;
        e.len  = len;
        e.b2b  = b2b;
        return e;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic q_pop(input int d, output exp_t e);
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
    endtask

    // Baud tick: every cycle when tick_div is 1, else one cycle in tick_div.
    initial begin
        tick = 1'b1;
        forever begin
            @(negedge clk);
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (tcnt == 0);
                tcnt = (tcnt + 1) % tick_div;
            end
        end
    end

    task automatic mon_step(input int d, input logic t);
        logic tx, fd, rdy;
        bit   ended;
        tx  = (d == 0) ? tx0 : tx1;
        fd  = (d == 0) ? done0 : done1;
        rdy = (d == 0) ? ready0 : ready1;
        ended = 1'b0;
        if (rst) begin
            in_fr[d] = 1'b0;
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end else if (!t) begin
            chk($sformatf("line_stable_%0d", d), tx, prev_tx[d]);
            chk($sformatf("done_off_tick_%0d", d), fd, 1'b0);
        end else begin
            if (in_fr[d]) begin
                idx[d]++;
                if (idx[d] < int'(cur[d].len)) begin
                    chk($sformatf("bit%0d_dut%0d", idx[d], d), tx, cur[d].bits[idx[d]]);
                    chk($sformatf("done_mid_%0d", d), fd, 1'b0);
                end else begin
                    chk($sformatf("frame_done_%0d", d), fd, 1'b1);
                    in_fr[d] = 1'b0;
                    ended    = 1'b1;
                end
            end else begin
                chk($sformatf("done_idle_%0d", d), fd, 1'b0);
            end
            if (!in_fr[d] && tx == 1'b0) begin
                chk($sformatf("frame_expected_%0d", d), q_size(d) != 0, 1'b1);
                if (q_size(d) != 0) begin
                    q_pop(d, cur[d]);
                    in_fr[d] = 1'b1;
                    idx[d]   = 0;
                    chk($sformatf("b2b_start_%0d", d), ended, cur[d].b2b);
                    chk($sformatf("ready_at_start_%0d", d), rdy, 1'b1);
                end
            end
        end
        prev_tx[d] = tx;
    endtask

    always begin
        @(posedge clk);
        mon_t = tick;
        #1;
        for (int d = 0; d < 2; d++) mon_step(d, mon_t);
    end

    task automatic send(input int d, input logic [7:0] w, input exp_t e);
        bit acc;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(negedge clk);
        data = w;
        if (d == 0) valid0 = 1'b1;
        else        valid1 = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            acc = (d == 0) ? ready0 : ready1;
            @(negedge clk);
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic wait_idle(input int d, input int budget);
        logic b;
        b = 1'b1;
        for (int i = 0; i < budget; i++) begin
            b = (d == 0) ? busy0 : busy1;
            if (!b) break;
            @(negedge clk);
        end
        chk($sformatf("idle_timeout_%0d", d), b, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; data = 8'h00; valid0 = 1'b0; valid1 = 1'b0;
        par_en = 1'b1; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", tx0, 1'b1);
        chk("rst_ready0", ready0, 1'b1);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_tx1", tx1, 1'b1);
        rst = 1'b0;

        // 0xA5, even parity, one stop bit
        send(0, 8'hA5, mk(16'b1_0_10100101_0, 5'd11, 1'b0));
        wait_idle(0, 100);
        repeat (5) @(negedge clk);
        chk("idle_line_after_a5", tx0, 1'b1);

        // 0xA5, odd parity, two stop bits
        par_typ = 1'b1;
        send(1, 8'hA5, mk(16'b11_1_10100101_0, 5'd12, 1'b0));
        wait_idle(1, 100);
        par_typ = 1'b0;

        // 0xA5 without parity
        par_en = 1'b0;
        send(0, 8'hA5, mk(16'b1_10100101_0, 5'd10, 1'b0));
        wait_idle(0, 100);
        par_en = 1'b1;

        // Back-to-back: 0xFF accepted while 0x00 is in its data bits
        send(0, 8'h00, mk(16'b1_0_00000000_0, 5'd11, 1'b0));
        repeat (4) @(negedge clk);
        chk("ready_before_2nd", ready0, 1'b1);
        send(0, 8'hFF, mk(16'b1_0_11111111_0, 5'd11, 1'b1));
        chk("ready_after_2nd", ready0, 1'b0);
        wait_idle(0, 200);

        // Slow baud, parity type toggled mid-frame
        tick_div = 16;
        send(0, 8'h3C, mk(16'b1_0_00111100_0, 5'd11, 1'b0));
        repeat (40) @(negedge clk);
        par_typ = 1'b1;
        wait_idle(0, 400);
        par_typ = 1'b0;

        // Valid while the buffer is full is ignored
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (tick) break;
        end
        send(0, 8'h81, mk(16'b1_0_10000001_0, 5'd11, 1'b0));
        data = 8'h7E;
        valid0 = 1'b1;
        @(negedge clk);
        chk("ready_while_full", ready0, 1'b0);
        @(negedge clk);
        valid0 = 1'b0;
        wait_idle(0, 400);

        // Reset in the middle of 0x55 with a second word buffered
        tick_div = 1;
        send(0, 8'h55, mk(16'b1_0_01010101_0, 5'd11, 1'b0));
        for (int i = 0; i < 50; i++) begin
            if (ready0) break;
            @(negedge clk);
        end
        send(0, 8'h33, mk(16'b1_0_00110011_0, 5'd11, 1'b0));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (tx0 == 1'b0) break;
            @(negedge clk);
        end
        chk("line_low_before_rst", tx0, 1'b0);
        rst = 1'b1;
        #1;
        chk("tx_async_reset", tx0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy_after_rst", busy0, 1'b0);
        chk("ready_after_rst", ready0, 1'b1);
        repeat (30) @(negedge clk);
        chk("no_resume_tx", tx0, 1'b1);
        chk("no_resume_busy", busy0, 1'b0);

        chk("pending_frames_0", exp_q0.size(), 0);
        chk("pending_frames_1", exp_q1.size(), 0);
        chk("open_frame_0", in_fr[0], 1'b0);
        chk("open_frame_1", in_fr[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
